// File: rtl/flit_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flit_tx_arbiter_pkg
//  Description : Shared definitions for flit_tx_arbiter: default flit width
//                (`SIZE), arbiter FSM state encoding, round-robin wrap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef SIZE
`define SIZE 8
`endif

package flit_tx_arbiter_pkg;

  localparam int ARB_DEF_W = `SIZE;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_HI = 2'd1,
    ARB_WAIT_LO = 2'd2
  } arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flit_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : flit_tx_arbiter_rr_pick
//  Description : Combinational round-robin find-first. Returns the first set
//                bit of i_valid at or above i_ptr, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_tx_arbiter_rr_pick
  import flit_tx_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_valid,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_winner,
  output logic           o_any_valid
);

  logic [IDW-1:0] w_hi_idx;
  logic [IDW-1:0] w_lo_idx;
  logic           w_hi_found;

  // Lowest valid index in the upper region [ptr, N) and in the whole vector;
  // the upper region wins so the search starts at ptr and wraps.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (i_valid[j]) begin
        w_lo_idx = IDW'(j);
        if (j >= int'(i_ptr)) begin
          w_hi_idx   = IDW'(j);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  assign o_winner    = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_any_valid = |i_valid;

endmodule
`default_nettype wire

// File: rtl/flit_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flit_tx_arbiter
//  Description : Shares one tx serializer among N flit sources. Each source
//                owns a one-entry holding slot; a round-robin scheduler hands
//                held flits to tx using the req-pulse / busy handshake.
//                Optional trace: define FLIT_ARB_TRACE_EN to print grant and
//                overflow events in simulation.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_tx_arbiter
  import flit_tx_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = ARB_DEF_W,
  parameter int IDW   = 2,
  parameter int GUARD = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   i_src_req,
  input  logic [N*W-1:0] i_src_data,
  output logic [N-1:0]   o_src_busy,
  output logic           o_tx_req,
  output logic [W-1:0]   o_tx_data,
  input  logic           i_tx_busy,
  output logic [IDW-1:0] o_grant_id,
  output logic [N-1:0]   o_overflow
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  logic [N-1:0]   r_valid;
  logic [W-1:0]   r_data [N];
  logic [N-1:0]   r_ovf;
  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [GW-1:0]  r_guard;
  logic [GW-1:0]  w_guard_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic           r_tx_req;
  logic [W-1:0]   r_tx_data;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] w_winner;
  logic           w_any_valid;
  logic           w_grant;
  logic [W-1:0]   w_win_data;

  flit_tx_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .i_valid     (r_valid),
    .i_ptr       (r_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  // Select the held flit of the current winner.
  always_comb begin
    w_win_data = '0;
    for (int j = 0; j < N; j++) begin
      if (w_winner == IDW'(j)) w_win_data = r_data[j];
    end
  end

  assign w_ptr_nxt = IDW'(rr_next(int'(w_winner), N));

  // Next-state logic: grant from IDLE, then wait for tx to show (and drop) busy.
  always_comb begin
    w_state_nxt = r_state;
    w_guard_nxt = r_guard;
    w_grant     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_valid && !i_tx_busy) begin
          w_grant     = 1'b1;
          w_state_nxt = ARB_WAIT_HI;
          w_guard_nxt = '0;
        end
      end
      ARB_WAIT_HI: begin
        if (i_tx_busy) begin
          w_state_nxt = ARB_WAIT_LO;
        end else if (r_guard == GW'(GUARD)) begin
          // tx took the flit without ever raising busy
          w_state_nxt = ARB_IDLE;
        end else begin
          w_guard_nxt = r_guard + 1'b1;
        end
      end
      ARB_WAIT_LO: begin
        if (!i_tx_busy) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM state, guard counter, rr pointer and registered tx-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_guard    <= '0;
      r_ptr      <= '0;
      r_tx_req   <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_guard  <= w_guard_nxt;
      r_tx_req <= w_grant;
      if (w_grant) begin
        r_tx_data  <= w_win_data;
        r_grant_id <= w_winner;
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  // Holding slots: capture into empty slots, drop and flag requests to full ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_ovf   <= '0;
      for (int i = 0; i < N; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_grant && (w_winner == IDW'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (i_src_req[i]) begin
          r_valid[i] <= 1'b1;
        end
        if (i_src_req[i] && !r_valid[i]) r_data[i] <= i_src_data[i*W +: W];
        if (i_src_req[i] && r_valid[i])  r_ovf[i]  <= 1'b1;
      end
    end
  end

`ifdef FLIT_ARB_TRACE_EN
  // Report grant and overflow events as they are committed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_grant) $display("arb grant src %d data %h", w_winner, w_win_data);
      for (int i = 0; i < N; i++) begin
        if (i_src_req[i] && r_valid[i]) $display("arb overflow src %d", i);
      end
    end
  end
`else
`endif

  assign o_src_busy = r_valid;
  assign o_tx_req   = r_tx_req;
  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant_id;
  assign o_overflow = r_ovf;

endmodule
`default_nettype wire
